// File: rtl/window_sched.sv
// window_sched: turns a row-major pixel raster into 3x3 windows.
// The incoming rows are stored in four circular row buffers. Three consecutive
// rows are scanned one column at a time while a fourth row is filled.
//
// Ports:
//   i_clk              single clock, rising edge
//   i_rstn             synchronous active-low reset
//   i_pixel_data       incoming pixel (8 bits), row-major
//   i_pixel_data_valid i_pixel_data valid this cycle
//   i_out_en           downstream enable; low stalls window issue
//   o_pixel_data       3x3 window: [23:0] top, [47:24] middle, [71:48] bottom,
//                      lowest byte of each row group is the leftmost column
//   o_pixel_data_valid o_pixel_data valid this cycle
//   o_intr             one-cycle pulse with the last window of each pass
//   o_overflow         sticky: an input pixel was dropped
module window_sched #(
   parameter int IMG_W = 512
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic [7:0]  i_pixel_data,
   input  logic        i_pixel_data_valid,
   input  logic        i_out_en,
   output logic [71:0] o_pixel_data,
   output logic        o_pixel_data_valid,
   output logic        o_intr,
   output logic        o_overflow
);

   localparam int PW = $clog2(IMG_W);
   localparam int CW = $clog2(4 * IMG_W + 1);

   localparam logic [PW-1:0] LAST_PTR  = PW'(IMG_W - 1);
   localparam logic [PW-1:0] LAST_COL  = PW'(IMG_W - 3);
   localparam logic [CW-1:0] CNT_FULL  = CW'(4 * IMG_W);
   localparam logic [CW-1:0] CNT_START = CW'(3 * IMG_W);
   localparam logic [CW-1:0] CNT_ROW   = CW'(IMG_W);

   typedef enum logic {IDLE, RD} state_t;

   state_t        state;
   state_t        state_next;

   logic [7:0]    row_buf [4][IMG_W];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_col;
   logic [1:0]    wr_sel;
   logic [1:0]    rd_sel;
   logic [CW-1:0] count;
   logic          issue;
   logic          pass_end;
   logic          accept;
   logic [71:0]   window;

   // A pass starts once three full rows are stored. Each enabled cycle in RD
   // issues one window; the issue at the last legal column closes the pass.
   always_comb begin
      state_next = state;
      issue      = 1'b0;
      pass_end   = 1'b0;
      case (state)
         IDLE: begin
            if (count >= CNT_START) begin
               state_next = RD;
            end
         end
         RD: begin
            if (i_out_en) begin
               issue = 1'b1;
               if (rd_col == LAST_COL) begin
                  pass_end   = 1'b1;
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // When all four buffers are full the only room that can appear is the row
   // released by a pass end in this same cycle. Since the writer then targets
   // the row being released, it never collides with a row still to be read.
   assign accept = i_pixel_data_valid && ((count != CNT_FULL) || pass_end);

   // Gather the three rows starting at rd_sel, columns rd_col..rd_col+2.
   always_comb begin
      window = '0;
      for (int r = 0; r < 3; r++) begin
         for (int k = 0; k < 3; k++) begin
            window[(r * 3 + k) * 8 +: 8] = row_buf[rd_sel + 2'(r)][rd_col + PW'(k)];
         end
      end
   end

   // Row storage is deliberately not reset; count restarting at zero keeps
   // stale contents from ever reaching the output.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         row_buf[wr_sel][wr_ptr] <= i_pixel_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         wr_ptr             <= '0;
         wr_sel             <= '0;
         rd_col             <= '0;
         rd_sel             <= '0;
         count              <= '0;
         o_pixel_data       <= '0;
         o_pixel_data_valid <= 1'b0;
         o_intr             <= 1'b0;
         o_overflow         <= 1'b0;
      end else begin
         if (accept) begin
            if (wr_ptr == LAST_PTR) begin
               wr_ptr <= '0;
               wr_sel <= wr_sel + 2'd1;
            end else begin
               wr_ptr <= wr_ptr + PW'(1);
            end
         end

         // Arrival and release of a row can coincide; both apply at once.
         count <= count + CW'(accept) - (pass_end ? CNT_ROW : '0);

         if (state == IDLE) begin
            rd_col <= '0;
         end else if (issue) begin
            rd_col <= rd_col + PW'(1);
         end

         if (pass_end) begin
            rd_sel <= rd_sel + 2'd1;
         end

         o_pixel_data_valid <= issue;
         o_intr             <= pass_end;
         if (issue) begin
            o_pixel_data <= window;
         end

         if (i_pixel_data_valid && !accept) begin
            o_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_window_sched.sv
// tb_window_sched: self-checking bench for window_sched with IMG_W = 8.
// The reference model keeps every accepted pixel in a queue; each completed
// row from the third onward releases one pass whose windows are computed
// straight from the raster and queued. A monitor thread pops and compares one
// entry per valid output window.
module tb_window_sched;

   localparam int W = 8;

   logic        i_clk = 1'b0;
   logic        i_rstn = 1'b0;
   logic [7:0]  i_pixel_data = '0;
   logic        i_pixel_data_valid = 1'b0;
   logic        i_out_en = 1'b0;
   logic [71:0] o_pixel_data;
   logic        o_pixel_data_valid;
   logic        o_intr;
   logic        o_overflow;

   window_sched #(.IMG_W(W)) dut (
      .i_clk              (i_clk),
      .i_rstn             (i_rstn),
      .i_pixel_data       (i_pixel_data),
      .i_pixel_data_valid (i_pixel_data_valid),
      .i_out_en           (i_out_en),
      .o_pixel_data       (o_pixel_data),
      .o_pixel_data_valid (o_pixel_data_valid),
      .o_intr             (o_intr),
      .o_overflow         (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [71:0] data;
      logic        intr;
   } exp_t;

   exp_t        exp_q[$];
   logic [7:0]  pix[$];
   logic [71:0] win_log [1024];
   int          tests = 0;
   int          fails = 0;
   int          win_total = 0;
   int          pass_total = 0;
   int          sent = 0;
   logic        exp_ovf = 1'b0;

   localparam logic [71:0] FIRST_WIN = {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0};
   localparam logic [71:0] LAST_WIN  = {8'd23, 8'd22, 8'd21, 8'd15, 8'd14, 8'd13, 8'd7, 8'd6, 8'd5};

   task automatic check_output(input string name, input logic [71:0] act, input logic [71:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic monitor_loop();
      exp_t e;
      forever begin
         @(negedge i_clk);
         if (!i_rstn) begin
            exp_q.delete();
         end else begin
            check_output("overflow flag", 72'(o_overflow), 72'(exp_ovf));
            if (o_pixel_data_valid) begin
               win_log[win_total % 1024] = o_pixel_data;
               win_total++;
               if (o_intr) pass_total++;
               if (exp_q.size() == 0) begin
                  check_output("unexpected window", 72'(1), 72'(0));
               end else begin
                  e = exp_q.pop_front();
                  check_output("window data", o_pixel_data, e.data);
                  check_output("window intr", 72'(o_intr), 72'(e.intr));
               end
            end else begin
               check_output("intr without window", 72'(o_intr), 72'(0));
            end
         end
      end
   endtask

   // Record an accepted pixel; a completed row r >= 2 releases pass r-2.
   task automatic model_accept(input logic [7:0] d);
      int   p;
      exp_t e;
      pix.push_back(d);
      if ((pix.size() % W == 0) && (pix.size() / W >= 3)) begin
         p = pix.size() / W - 3;
         for (int c = 0; c <= W - 3; c++) begin
            e.data = '0;
            for (int r = 0; r < 3; r++) begin
               for (int k = 0; k < 3; k++) begin
                  e.data[(r * 3 + k) * 8 +: 8] = pix[(p + r) * W + c + k];
               end
            end
            e.intr = (c == W - 3);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic en);
      i_pixel_data_valid = v;
      i_pixel_data       = d;
      i_out_en           = en;
      @(posedge i_clk);
      #1;
      i_pixel_data_valid = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic en);
      model_accept(d);
      sent++;
      apply_stimulus(1'b1, d, en);
   endtask

   task automatic do_reset();
      i_rstn             = 1'b0;
      i_pixel_data_valid = 1'b0;
      i_out_en           = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      check_output("reset valid", 72'(o_pixel_data_valid), 72'(0));
      check_output("reset intr", 72'(o_intr), 72'(0));
      check_output("reset overflow", 72'(o_overflow), 72'(0));
      check_output("reset data", o_pixel_data, 72'(0));
      pix.delete();
      sent    = 0;
      exp_ovf = 1'b0;
      #1;
      i_rstn = 1'b1;
   endtask

   task automatic drain(input bit toggle);
      int   n;
      logic en;
      n  = 0;
      en = 1'b1;
      while (exp_q.size() != 0 && n < 400) begin
         apply_stimulus(1'b0, 8'd0, en);
         if (toggle) en = !en;
         n++;
      end
      check_output("drain timeout", 72'(exp_q.size()), 72'(0));
      for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 8'd0, 1'b1);
   endtask

   task automatic ramp_pass(input bit toggle);
      int base;
      do_reset();
      base = win_total;
      for (int i = 0; i < 24; i++) send(8'(i), toggle ? 1'(i % 2 == 0) : 1'b1);
      drain(toggle);
      check_output("ramp window count", 72'(win_total - base), 72'(6));
      check_output("ramp first window", win_log[base % 1024], FIRST_WIN);
      check_output("ramp last window", win_log[(base + 5) % 1024], LAST_WIN);
   endtask

   initial begin
      int base;
      int pbase;
      int n;
      logic en;

      fork
         monitor_loop();
      join_none

      // Two rows only: no pass may start.
      do_reset();
      base = win_total;
      for (int i = 0; i < 16; i++) send(8'(i), 1'b1);
      for (int i = 0; i < 20; i++) apply_stimulus(1'b0, 8'd0, 1'b1);
      check_output("two rows no window", 72'(win_total - base), 72'(0));

      // Three-row ramp, continuous and with out_en toggling.
      ramp_pass(1'b0);
      ramp_pass(1'b1);

      // Fill all four buffers with out_en low; the 33rd pixel is dropped.
      do_reset();
      for (int i = 0; i < 32; i++) send(8'($urandom), 1'b0);
      apply_stimulus(1'b1, 8'hAA, 1'b0);
      exp_ovf = 1'b1;
      for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 8'd0, 1'b0);
      drain(1'b0);
      check_output("overflow sticky", 72'(o_overflow), 72'(1));

      // Full buffers, pixel arrives on the pass-end cycle and is accepted.
      do_reset();
      for (int i = 0; i < 32; i++) send(8'($urandom), 1'b0);
      for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 8'd0, 1'b1);
      send(8'($urandom), 1'b1);
      for (int i = 0; i < 7; i++) send(8'($urandom), 1'b1);
      drain(1'b0);

      // Random traffic, flow-limited so nothing is ever dropped.
      do_reset();
      pbase = pass_total;
      for (int cyc = 0; cyc < 600; cyc++) begin
         en = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) != 0 && (sent - W * (pass_total - pbase)) < 4 * W) begin
            send(8'($urandom), en);
         end else begin
            apply_stimulus(1'b0, 8'd0, en);
         end
      end
      drain(1'b0);

      // Reset lands on the edge that would register the third window.
      do_reset();
      base = win_total;
      for (int i = 0; i < 24; i++) send(8'(i), 1'b1);
      n = 0;
      while ((win_total - base) < 2 && n < 100) begin
         @(negedge i_clk);
         #1;
         n++;
      end
      check_output("second window timeout", 72'((win_total - base) >= 2), 72'(1));
      do_reset();
      check_output("window discarded by reset", 72'(win_total - base), 72'(2));
      ramp_pass(1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
